// File: rtl/dispatch_queue_pkg.sv
// Shared opcode encodings, sentinel tags and instruction classification helpers.
package dispatch_queue_pkg;

   localparam int unsigned DEF_REG_WIDTH = 5;
   localparam int unsigned DEF_ROB_WIDTH = 4;
   // Sentinels for the default widths; modules derive width-matched copies locally.
   localparam int unsigned NON_REG = 1 << DEF_REG_WIDTH;
   localparam int unsigned NON_DEP = 1 << DEF_ROB_WIDTH;

   typedef enum logic [6:0] {
      OpNone = 7'd0,
      OpLui, OpAuipc, OpJal, OpJalr,
      OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
      OpLb, OpLh, OpLw, OpLbu, OpLhu,
      OpSb, OpSh, OpSw,
      OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi, OpSlli, OpSrli, OpSrai,
      OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAndd
   } opcode_e;

   function automatic logic is_ls(input logic [6:0] op);
      return (op >= OpLb) && (op <= OpSw);
   endfunction

   function automatic logic is_branch(input logic [6:0] op);
      return (op >= OpBeq) && (op <= OpBgeu);
   endfunction

   function automatic logic is_store(input logic [6:0] op);
      return (op >= OpSb) && (op <= OpSw);
   endfunction

   function automatic logic is_rtype(input logic [6:0] op);
      return (op >= OpAdd) && (op <= OpAndd);
   endfunction

   function automatic logic uses_rs1(input logic [6:0] op);
      return !((op == OpLui) || (op == OpAuipc) || (op == OpJal));
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return is_branch(op) || is_store(op) || is_rtype(op);
   endfunction

endpackage

// File: rtl/dispatch_queue_operand_resolve.sv
// Resolves one source operand from RF tag/value, RoB probe and CDB broadcasts.
module operand_resolve #(
   parameter int unsigned ROB_WIDTH = 4,
   parameter int unsigned NUM_CDB   = 2
) (
   input  logic [ROB_WIDTH:0]           rf_q,
   input  logic [31:0]                  rf_v,
   input  logic                         rob_ready,
   input  logic [31:0]                  rob_v,
   input  logic [NUM_CDB-1:0]           cdb_en,
   input  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_idx,
   input  logic [NUM_CDB*32-1:0]        cdb_val,
   output logic [ROB_WIDTH:0]           res_q,
   output logic [31:0]                  res_v
);

   localparam logic [ROB_WIDTH:0] NON_DEP_TAG = {1'b1, {ROB_WIDTH{1'b0}}};

   // Priority: ready in RF, ready in RoB, then lowest-numbered matching CDB channel.
   always_comb begin
      res_q = rf_q;
      res_v = rf_v;
      if (rf_q != NON_DEP_TAG) begin
         if (rob_ready) begin
            res_q = NON_DEP_TAG;
            res_v = rob_v;
         end else begin
            // Scan high to low so the lowest matching channel wins.
            for (int i = NUM_CDB - 1; i >= 0; i--) begin
               if (cdb_en[i] && (cdb_idx[i*ROB_WIDTH +: ROB_WIDTH] == rf_q[ROB_WIDTH-1:0])) begin
                  res_q = NON_DEP_TAG;
                  res_v = cdb_val[i*32 +: 32];
               end
            end
         end
      end
   end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: buffers decoded instructions and issues the head to RS/LSB/RoB.
module dispatch_queue
   import dispatch_queue_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned REG_WIDTH  = 5,
   parameter int unsigned ROB_WIDTH  = 4,
   parameter int unsigned DQ_DEPTH   = 4,
   parameter int unsigned NUM_CDB    = 2
) (
   input  logic                         Sys_clk,
   input  logic                         Sys_rst,
   input  logic                         Sys_rdy,
   input  logic                         DCDP_en,
   output logic                         DPDC_ready,
   input  logic [ADDR_WIDTH-1:0]        DCDP_pc,
   input  logic [6:0]                   DCDP_opcode,
   input  logic [REG_WIDTH-1:0]         DCDP_rs1,
   input  logic [REG_WIDTH-1:0]         DCDP_rs2,
   input  logic [REG_WIDTH-1:0]         DCDP_rd,
   input  logic [31:0]                  DCDP_imm,
   input  logic                         DCDP_predict,
   output logic [REG_WIDTH:0]           DPRF_rs1,
   output logic [REG_WIDTH:0]           DPRF_rs2,
   input  logic [ROB_WIDTH:0]           RFDP_Qj,
   input  logic [ROB_WIDTH:0]           RFDP_Qk,
   input  logic [31:0]                  RFDP_Vj,
   input  logic [31:0]                  RFDP_Vk,
   output logic [ROB_WIDTH:0]           DPRoB_Qj,
   output logic [ROB_WIDTH:0]           DPRoB_Qk,
   input  logic                         RoBDP_Qj_ready,
   input  logic                         RoBDP_Qk_ready,
   input  logic [31:0]                  RoBDP_Vj,
   input  logic [31:0]                  RoBDP_Vk,
   input  logic                         RoBDP_full,
   input  logic [ROB_WIDTH-1:0]         RoBDP_RoB_index,
   input  logic                         RoBDP_flush,
   input  logic                         RSDP_full,
   input  logic                         LSBDP_full,
   input  logic [NUM_CDB-1:0]           CDB_en,
   input  logic [NUM_CDB*ROB_WIDTH-1:0] CDB_RoB_index,
   input  logic [NUM_CDB*32-1:0]        CDB_value,
   output logic                         DPRS_en,
   output logic                         DPLSB_en,
   output logic                         DPRoB_en,
   output logic                         DPRF_en,
   output logic [ADDR_WIDTH-1:0]        DP_pc,
   output logic [6:0]                   DP_opcode,
   output logic [31:0]                  DP_imm,
   output logic                         DP_predict,
   output logic [ROB_WIDTH:0]           DP_Qj,
   output logic [ROB_WIDTH:0]           DP_Qk,
   output logic [31:0]                  DP_Vj,
   output logic [31:0]                  DP_Vk,
   output logic [REG_WIDTH:0]           DP_rd,
   output logic [ROB_WIDTH-1:0]         DP_RoB_index
);

   localparam int unsigned PTR_W = $clog2(DQ_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [REG_WIDTH:0] NON_REG_TAG = {1'b1, {REG_WIDTH{1'b0}}};
   localparam logic [ROB_WIDTH:0] NON_DEP_TAG = {1'b1, {ROB_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] pc_mem   [DQ_DEPTH];
   logic [6:0]            op_mem   [DQ_DEPTH];
   logic [REG_WIDTH-1:0]  rs1_mem  [DQ_DEPTH];
   logic [REG_WIDTH-1:0]  rs2_mem  [DQ_DEPTH];
   logic [REG_WIDTH-1:0]  rd_mem   [DQ_DEPTH];
   logic [31:0]           imm_mem  [DQ_DEPTH];
   logic                  pred_mem [DQ_DEPTH];

   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [6:0]       head_op;
   logic             head_ls, do_enq, do_iss;
   logic [REG_WIDTH:0] issue_rd;
   logic [ROB_WIDTH:0] res_qj, res_qk;
   logic [31:0]        res_vj, res_vk;

   operand_resolve #(.ROB_WIDTH(ROB_WIDTH), .NUM_CDB(NUM_CDB)) u_resolve_j (
      .rf_q      (RFDP_Qj),
      .rf_v      (RFDP_Vj),
      .rob_ready (RoBDP_Qj_ready),
      .rob_v     (RoBDP_Vj),
      .cdb_en    (CDB_en),
      .cdb_idx   (CDB_RoB_index),
      .cdb_val   (CDB_value),
      .res_q     (res_qj),
      .res_v     (res_vj)
   );

   operand_resolve #(.ROB_WIDTH(ROB_WIDTH), .NUM_CDB(NUM_CDB)) u_resolve_k (
      .rf_q      (RFDP_Qk),
      .rf_v      (RFDP_Vk),
      .rob_ready (RoBDP_Qk_ready),
      .rob_v     (RoBDP_Vk),
      .cdb_en    (CDB_en),
      .cdb_idx   (CDB_RoB_index),
      .cdb_val   (CDB_value),
      .res_q     (res_qk),
      .res_v     (res_vk)
   );

   // Handshake, issue decision, head register lookup and occupancy update.
   always_comb begin
      head_op    = op_mem[head_q];
      head_ls    = is_ls(head_op);
      DPDC_ready = Sys_rdy & ~Sys_rst & ~RoBDP_flush & (count_q != CNT_W'(DQ_DEPTH));
      do_enq     = DCDP_en & DPDC_ready;
      do_iss     = Sys_rdy & ~RoBDP_flush & (count_q != '0) & ~RoBDP_full &
                   (head_ls ? ~LSBDP_full : ~RSDP_full);
      DPRF_rs1   = uses_rs1(head_op) ? {1'b0, rs1_mem[head_q]} : NON_REG_TAG;
      DPRF_rs2   = uses_rs2(head_op) ? {1'b0, rs2_mem[head_q]} : NON_REG_TAG;
      DPRoB_Qj   = RFDP_Qj;
      DPRoB_Qk   = RFDP_Qk;
      issue_rd   = (is_branch(head_op) || is_store(head_op)) ? NON_REG_TAG
                                                             : {1'b0, rd_mem[head_q]};
      case ({do_enq, do_iss})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Entry storage; contents are meaningless outside head..tail so no reset is needed.
   always_ff @(posedge Sys_clk) begin
      if (do_enq) begin
         pc_mem[tail_q]   <= DCDP_pc;
         op_mem[tail_q]   <= DCDP_opcode;
         rs1_mem[tail_q]  <= DCDP_rs1;
         rs2_mem[tail_q]  <= DCDP_rs2;
         rd_mem[tail_q]   <= DCDP_rd;
         imm_mem[tail_q]  <= DCDP_imm;
         pred_mem[tail_q] <= DCDP_predict;
      end
   end

   // Pointers, count, issue strobes and registered issue payload.
   always_ff @(posedge Sys_clk or posedge Sys_rst) begin
      if (Sys_rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         DPRS_en      <= 1'b0;
         DPLSB_en     <= 1'b0;
         DPRoB_en     <= 1'b0;
         DPRF_en      <= 1'b0;
         DP_pc        <= '0;
         DP_opcode    <= '0;
         DP_imm       <= '0;
         DP_predict   <= 1'b0;
         DP_Qj        <= NON_DEP_TAG;
         DP_Qk        <= NON_DEP_TAG;
         DP_Vj        <= '0;
         DP_Vk        <= '0;
         DP_rd        <= '0;
         DP_RoB_index <= '0;
      end else if (Sys_rdy) begin
         if (RoBDP_flush) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            DPRS_en  <= 1'b0;
            DPLSB_en <= 1'b0;
            DPRoB_en <= 1'b0;
            DPRF_en  <= 1'b0;
         end else begin
            if (do_enq) tail_q <= tail_q + PTR_W'(1);
            if (do_iss) head_q <= head_q + PTR_W'(1);
            count_q  <= count_d;
            DPRS_en  <= do_iss & ~head_ls;
            DPLSB_en <= do_iss & head_ls;
            DPRoB_en <= do_iss;
            DPRF_en  <= do_iss;
            if (do_iss) begin
               DP_pc        <= pc_mem[head_q];
               DP_opcode    <= head_op;
               DP_imm       <= imm_mem[head_q];
               DP_predict   <= pred_mem[head_q];
               DP_Qj        <= res_qj;
               DP_Qk        <= res_qk;
               DP_Vj        <= res_vj;
               DP_Vk        <= res_vk;
               DP_rd        <= issue_rd;
               DP_RoB_index <= RoBDP_RoB_index;
            end
         end
      end
   end

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized bench for dispatch_queue against a queue-based reference model.
module tb_dispatch_queue;

   localparam int unsigned NDEP  = 16;
   localparam int unsigned NREG  = 32;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [6:0]  op;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic        pred;
   } ent_t;

   logic        clk, rst, rdy, dc_en, dc_ready, dc_pred;
   logic [31:0] dc_pc, dc_imm;
   logic [6:0]  dc_op;
   logic [4:0]  dc_rs1, dc_rs2, dc_rd;
   logic [5:0]  rf_rs1, rf_rs2;
   logic [4:0]  rf_qj, rf_qk, rob_qj, rob_qk;
   logic [31:0] rf_vj, rf_vk, rob_vj, rob_vk;
   logic        rob_rj, rob_rk, rob_full, flush, rs_full, lsb_full;
   logic [3:0]  rob_idx;
   logic [1:0]  cdb_en;
   logic [3:0]  cdb_idx [2];
   logic [31:0] cdb_val [2];
   logic [7:0]  cdb_idx_p;
   logic [63:0] cdb_val_p;
   logic        o_rs, o_lsb, o_rob, o_rf, o_pred;
   logic [31:0] o_pc, o_imm, o_vj, o_vk;
   logic [6:0]  o_op;
   logic [4:0]  o_qj, o_qk;
   logic [5:0]  o_rd;
   logic [3:0]  o_robi;

   assign cdb_idx_p = {cdb_idx[1], cdb_idx[0]};
   assign cdb_val_p = {cdb_val[1], cdb_val[0]};

   dispatch_queue dut (
      .Sys_clk(clk), .Sys_rst(rst), .Sys_rdy(rdy), .DCDP_en(dc_en), .DPDC_ready(dc_ready),
      .DCDP_pc(dc_pc), .DCDP_opcode(dc_op), .DCDP_rs1(dc_rs1), .DCDP_rs2(dc_rs2),
      .DCDP_rd(dc_rd), .DCDP_imm(dc_imm), .DCDP_predict(dc_pred),
      .DPRF_rs1(rf_rs1), .DPRF_rs2(rf_rs2), .RFDP_Qj(rf_qj), .RFDP_Qk(rf_qk),
      .RFDP_Vj(rf_vj), .RFDP_Vk(rf_vk), .DPRoB_Qj(rob_qj), .DPRoB_Qk(rob_qk),
      .RoBDP_Qj_ready(rob_rj), .RoBDP_Qk_ready(rob_rk), .RoBDP_Vj(rob_vj), .RoBDP_Vk(rob_vk),
      .RoBDP_full(rob_full), .RoBDP_RoB_index(rob_idx), .RoBDP_flush(flush),
      .RSDP_full(rs_full), .LSBDP_full(lsb_full), .CDB_en(cdb_en),
      .CDB_RoB_index(cdb_idx_p), .CDB_value(cdb_val_p),
      .DPRS_en(o_rs), .DPLSB_en(o_lsb), .DPRoB_en(o_rob), .DPRF_en(o_rf),
      .DP_pc(o_pc), .DP_opcode(o_op), .DP_imm(o_imm), .DP_predict(o_pred),
      .DP_Qj(o_qj), .DP_Qk(o_qk), .DP_Vj(o_vj), .DP_Vk(o_vk), .DP_rd(o_rd),
      .DP_RoB_index(o_robi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   ent_t mq[$];
   logic        e_rs, e_lsb, e_iss, e_pred;
   logic [31:0] e_pc, e_imm, e_vj, e_vk;
   logic [6:0]  e_op;
   logic [4:0]  e_qj, e_qk;
   logic [5:0]  e_rd;
   logic [3:0]  e_robi;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic m_ls(input logic [6:0] op);  return op >= 11 && op <= 18; endfunction
   function automatic logic m_br(input logic [6:0] op);  return op >= 5 && op <= 10;  endfunction
   function automatic logic m_st(input logic [6:0] op);  return op >= 16 && op <= 18; endfunction
   function automatic logic m_rt(input logic [6:0] op);  return op >= 28 && op <= 37; endfunction

   // Operand source priority: RF ready, then RoB, then lowest matching CDB channel.
   task automatic resolve(input logic [4:0] q, input logic [31:0] v, input logic rr,
                          input logic [31:0] rv, output logic [4:0] qo, output logic [31:0] vo);
      logic found;
      qo = q;
      vo = v;
      found = 1'b0;
      if (q != 5'(NDEP)) begin
         if (rr) begin
            qo = 5'(NDEP);
            vo = rv;
         end else begin
            for (int c = 0; c < 2; c++) begin
               if (!found && cdb_en[c] && cdb_idx[c] == q[3:0]) begin
                  found = 1'b1;
                  qo = 5'(NDEP);
                  vo = cdb_val[c];
               end
            end
         end
      end
   endtask

   task automatic model_reset();
      mq.delete();
      {e_rs, e_lsb, e_iss, e_pred} = '0;
      {e_pc, e_imm, e_vj, e_vk, e_op, e_rd, e_robi} = '0;
      e_qj = 5'(NDEP);
      e_qk = 5'(NDEP);
   endtask

   task automatic drive_random(input int cyc);
      logic stall;
      stall = ((cyc / 40) % 3) == 1;  // periodic windows that let the queue fill up
      rdy      = $urandom_range(0, 9) != 0;
      flush    = $urandom_range(0, 39) == 0;
      dc_en    = $urandom_range(0, 9) < 6;
      dc_pc    = $urandom;
      dc_op    = 7'($urandom_range(1, 37));
      dc_rs1   = 5'($urandom);
      dc_rs2   = 5'($urandom);
      dc_rd    = 5'($urandom);
      dc_imm   = $urandom;
      dc_pred  = 1'($urandom);
      rf_qj    = ($urandom_range(0, 2) == 0) ? 5'(NDEP) : 5'($urandom_range(0, 3));
      rf_qk    = ($urandom_range(0, 2) == 0) ? 5'(NDEP) : 5'($urandom_range(0, 3));
      rf_vj    = $urandom;
      rf_vk    = $urandom;
      rob_rj   = $urandom_range(0, 2) == 0;
      rob_rk   = $urandom_range(0, 2) == 0;
      rob_vj   = $urandom;
      rob_vk   = $urandom;
      rob_full = !stall && $urandom_range(0, 5) == 0;
      rob_idx  = 4'($urandom);
      rs_full  = stall || $urandom_range(0, 3) == 0;
      lsb_full = stall || $urandom_range(0, 3) == 0;
      cdb_en   = 2'($urandom);
      for (int c = 0; c < 2; c++) begin
         cdb_idx[c] = 4'($urandom_range(0, 3));
         cdb_val[c] = $urandom;
      end
   endtask

   // Predict the effect of the coming clock edge from current inputs.
   task automatic model_edge();
      ent_t h, n;
      logic ready, iss, ls;
      if (!rdy) return;
      if (flush) begin
         mq.delete();
         {e_rs, e_lsb, e_iss} = '0;
         return;
      end
      ready = mq.size() < DEPTH;
      iss = 1'b0;
      ls  = 1'b0;
      if (mq.size() > 0) begin
         ls  = m_ls(mq[0].op);
         iss = !rob_full && (ls ? !lsb_full : !rs_full);
      end
      if (iss) begin
         h = mq.pop_front();
         e_pc   = h.pc;
         e_op   = h.op;
         e_imm  = h.imm;
         e_pred = h.pred;
         e_rd   = (m_br(h.op) || m_st(h.op)) ? 6'(NREG) : {1'b0, h.rd};
         e_robi = rob_idx;
         resolve(rf_qj, rf_vj, rob_rj, rob_vj, e_qj, e_vj);
         resolve(rf_qk, rf_vk, rob_rk, rob_vk, e_qk, e_vk);
      end
      e_rs  = iss && !ls;
      e_lsb = iss && ls;
      e_iss = iss;
      if (dc_en && ready) begin
         n.pc = dc_pc; n.op = dc_op; n.rs1 = dc_rs1; n.rs2 = dc_rs2;
         n.rd = dc_rd; n.imm = dc_imm; n.pred = dc_pred;
         mq.push_back(n);
      end
   endtask

   task automatic check_comb();
      logic [6:0] op;
      check_eq("ready", 64'(dc_ready), 64'(rdy && !flush && mq.size() < DEPTH));
      check_eq("rob_qj", 64'(rob_qj), 64'(rf_qj));
      check_eq("rob_qk", 64'(rob_qk), 64'(rf_qk));
      if (mq.size() > 0) begin
         op = mq[0].op;
         check_eq("rf_rs1", 64'(rf_rs1), (op > 3) ? 64'(mq[0].rs1) : 64'(NREG));
         check_eq("rf_rs2", 64'(rf_rs2),
                  (m_br(op) || m_st(op) || m_rt(op)) ? 64'(mq[0].rs2) : 64'(NREG));
      end
   endtask

   task automatic check_outputs(input string pfx);
      check_eq({pfx, "rs_en"}, 64'(o_rs), 64'(e_rs));
      check_eq({pfx, "lsb_en"}, 64'(o_lsb), 64'(e_lsb));
      check_eq({pfx, "rob_en"}, 64'(o_rob), 64'(e_iss));
      check_eq({pfx, "rf_en"}, 64'(o_rf), 64'(e_iss));
      check_eq({pfx, "pc"}, 64'(o_pc), 64'(e_pc));
      check_eq({pfx, "op"}, 64'(o_op), 64'(e_op));
      check_eq({pfx, "imm"}, 64'(o_imm), 64'(e_imm));
      check_eq({pfx, "pred"}, 64'(o_pred), 64'(e_pred));
      check_eq({pfx, "qj"}, 64'(o_qj), 64'(e_qj));
      check_eq({pfx, "qk"}, 64'(o_qk), 64'(e_qk));
      check_eq({pfx, "vj"}, 64'(o_vj), 64'(e_vj));
      check_eq({pfx, "vk"}, 64'(o_vk), 64'(e_vk));
      check_eq({pfx, "rd"}, 64'(o_rd), 64'(e_rd));
      check_eq({pfx, "robi"}, 64'(o_robi), 64'(e_robi));
   endtask

   initial begin
      int next_rst;
      rst = 1'b0;
      drive_random(0);
      rdy = 1'b1;
      dc_en = 1'b1;
      model_reset();
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_ready", 64'(dc_ready), 64'(0));
      check_outputs("rst_");
      @(negedge clk);
      rst = 1'b0;
      next_rst = 300;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         drive_random(cyc);
         #1;
         check_comb();
         model_edge();
         @(posedge clk);
         #1;
         check_outputs("");
         // Asynchronous reset pulse between edges while an issue is on the outputs.
         if (e_iss && cyc >= next_rst) begin
            next_rst = cyc + 400;
            #1 rst = 1'b1;
            #1;
            model_reset();
            check_eq("arst_ready", 64'(dc_ready), 64'(0));
            check_outputs("arst_");
            rst = 1'b0;
         end
         @(negedge clk);
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
